// File: rtl/multi_queue_linked_list_fifo_if.sv
// Handshake bundle for the shared-buffer multi-queue FIFO: push/pop requests
// from the master, per-queue status and head data back from the slave.
interface multi_queue_linked_list_fifo_if #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_FIFOS = 4,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
);
    logic                           push;
    logic [SEL_WIDTH-1:0]           push_sel;
    logic [WIDTH-1:0]               data_in;
    logic                           pop;
    logic [SEL_WIDTH-1:0]           pop_sel;
    logic [WIDTH-1:0]               data_out;
    logic [NUM_FIFOS-1:0]           empty;
    logic [NUM_FIFOS-1:0]           full;
    logic [NUM_FIFOS*CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0]           free_count;
    logic                           push_err;
    logic                           pop_err;

    modport master (
        output push, push_sel, data_in, pop, pop_sel,
        input  data_out, empty, full, count, free_count, push_err, pop_err
    );

    modport slave (
        input  push, push_sel, data_in, pop, pop_sel,
        output data_out, empty, full, count, free_count, push_err, pop_err
    );
endinterface

// File: rtl/multi_queue_linked_list_fifo.sv
// NUM_FIFOS logical FIFOs sharing one DEPTH-entry array; every queue and the
// free pool are singly linked lists threaded through a common next-pointer table.
module multi_queue_linked_list_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 8,
    parameter int NUM_FIFOS    = 4,
    parameter int MAX_PER_FIFO = DEPTH,
    parameter int PTR_WIDTH    = $clog2(DEPTH),
    parameter int SEL_WIDTH    = $clog2(NUM_FIFOS),
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    multi_queue_linked_list_fifo_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PER_FIFO);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     mem  [DEPTH];
    logic [PTR_WIDTH-1:0] nxt  [DEPTH];
    logic [PTR_WIDTH-1:0] head [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] cnt  [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] free_head;
    logic [PTR_WIDTH-1:0] free_tail;
    logic [CNT_WIDTH-1:0] free_cnt;
    logic                 push_err_q;
    logic                 pop_err_q;

    logic [PTR_WIDTH-1:0] head_n [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] tail_n [NUM_FIFOS];
    logic [CNT_WIDTH-1:0] cnt_n  [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] free_head_n;
    logic [PTR_WIDTH-1:0] free_tail_n;
    logic [CNT_WIDTH-1:0] free_cnt_n;
    logic [CNT_WIDTH-1:0] free_left;

    logic                 qlink_we;
    logic [PTR_WIDTH-1:0] qlink_addr;
    logic [PTR_WIDTH-1:0] qlink_data;
    logic                 flink_we;
    logic [PTR_WIDTH-1:0] flink_addr;
    logic [PTR_WIDTH-1:0] flink_data;

    logic [NUM_FIFOS-1:0]           empty_v;
    logic [NUM_FIFOS-1:0]           full_v;
    logic [NUM_FIFOS*CNT_WIDTH-1:0] count_v;
    logic                           push_ok;
    logic                           pop_ok;
    logic                           push_same;
    logic [PTR_WIDTH-1:0]           alloc_e;
    logic [PTR_WIDTH-1:0]           rel_e;

    always_comb begin
        count_v = '0;
        for (int q = 0; q < NUM_FIFOS; q++) begin
            empty_v[q] = (cnt[q] == '0);
            full_v[q]  = (cnt[q] == MAX_CNT) || (free_cnt == '0);
            count_v[q*CNT_WIDTH +: CNT_WIDTH] = cnt[q];
        end
    end

    assign push_ok   = bus.push && !full_v[bus.push_sel];
    assign pop_ok    = bus.pop && !empty_v[bus.pop_sel];
    assign push_same = push_ok && pop_ok && (bus.push_sel == bus.pop_sel);
    assign alloc_e   = free_head;
    assign rel_e     = head[bus.pop_sel];
    assign free_left = push_ok ? free_cnt - ONE : free_cnt;

    always_comb begin
        head_n      = head;
        tail_n      = tail;
        cnt_n       = cnt;
        free_head_n = free_head;
        free_tail_n = free_tail;
        free_cnt_n  = free_cnt;
        qlink_we    = 1'b0;
        qlink_addr  = '0;
        qlink_data  = '0;
        flink_we    = 1'b0;
        flink_addr  = '0;
        flink_data  = '0;

        if (push_ok) begin
            if (empty_v[bus.push_sel]) begin
                head_n[bus.push_sel] = alloc_e;
            end else begin
                qlink_we   = 1'b1;
                qlink_addr = tail[bus.push_sel];
                qlink_data = alloc_e;
            end
            tail_n[bus.push_sel] = alloc_e;
            cnt_n[bus.push_sel]  = cnt_n[bus.push_sel] + ONE;
            free_head_n          = nxt[free_head];
        end

        if (pop_ok) begin
            // A one-entry queue that is pushed and popped together has no
            // committed successor link yet, so the new head is the fresh entry.
            if (push_same && cnt[bus.pop_sel] == ONE)
                head_n[bus.pop_sel] = alloc_e;
            else
                head_n[bus.pop_sel] = nxt[rel_e];
            cnt_n[bus.pop_sel] = cnt_n[bus.pop_sel] - ONE;
            // Released entry joins the free tail, after any same-cycle allocation.
            if (free_left == '0) begin
                free_head_n = rel_e;
            end else begin
                flink_we   = 1'b1;
                flink_addr = free_tail;
                flink_data = rel_e;
            end
            free_tail_n = rel_e;
        end

        if (push_ok && !pop_ok)
            free_cnt_n = free_cnt - ONE;
        else if (pop_ok && !push_ok)
            free_cnt_n = free_cnt + ONE;
    end

    // ---- state update at the clock edge ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < NUM_FIFOS; q++) begin
                head[q] <= '0;
                tail[q] <= '0;
                cnt[q]  <= '0;
            end
            for (int i = 0; i < DEPTH; i++)
                nxt[i] <= PTR_WIDTH'((i + 1) % DEPTH);
            free_head  <= '0;
            free_tail  <= PTR_WIDTH'(DEPTH - 1);
            free_cnt   <= CNT_WIDTH'(DEPTH);
            push_err_q <= 1'b0;
            pop_err_q  <= 1'b0;
        end else begin
            head      <= head_n;
            tail      <= tail_n;
            cnt       <= cnt_n;
            free_head <= free_head_n;
            free_tail <= free_tail_n;
            free_cnt  <= free_cnt_n;
            if (qlink_we)
                nxt[qlink_addr] <= qlink_data;
            if (flink_we)
                nxt[flink_addr] <= flink_data;
            push_err_q <= bus.push && !push_ok;
            pop_err_q  <= bus.pop && !pop_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !rst)
            mem[alloc_e] <= bus.data_in;
    end

    assign bus.data_out   = mem[head[bus.pop_sel]];
    assign bus.empty      = empty_v;
    assign bus.full       = full_v;
    assign bus.count      = count_v;
    assign bus.free_count = free_cnt;
    assign bus.push_err   = push_err_q;
    assign bus.pop_err    = pop_err_q;

    function automatic int total_entries();
        int sum;
        sum = int'(free_cnt);
        for (int q = 0; q < NUM_FIFOS; q++)
            sum += int'(cnt[q]);
        return sum;
    endfunction

    function automatic logic caps_ok();
        logic ok;
        ok = 1'b1;
        for (int q = 0; q < NUM_FIFOS; q++)
            if (cnt[q] > MAX_CNT) ok = 1'b0;
        return ok;
    endfunction

    // Walk every queue and the free list; each entry must be owned exactly once.
    function automatic logic lists_ok();
        logic [DEPTH-1:0]     seen;
        logic                 ok;
        logic [PTR_WIDTH-1:0] p;
        seen = '0;
        ok   = 1'b1;
        for (int q = 0; q < NUM_FIFOS; q++) begin
            p = head[q];
            for (int k = 0; k < DEPTH; k++) begin
                if (k < int'(cnt[q])) begin
                    if (seen[p]) ok = 1'b0;
                    seen[p] = 1'b1;
                    p = nxt[p];
                end
            end
        end
        p = free_head;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(free_cnt)) begin
                if (seen[p]) ok = 1'b0;
                seen[p] = 1'b1;
                p = nxt[p];
            end
        end
        return ok && (seen == '1);
    endfunction

    a_conserve: assert property (@(posedge clk) disable iff (rst) total_entries() == DEPTH);
    a_caps:     assert property (@(posedge clk) disable iff (rst) caps_ok());
    a_lists:    assert property (@(posedge clk) disable iff (rst) lists_ok());

endmodule

// File: tb/tb_multi_queue_linked_list_fifo.sv
// Bench for the shared-buffer multi-queue FIFO: two instances (cap 4 and cap 2)
// checked every cycle against per-queue FIFO models through a scoreboard.
module tb_multi_queue_linked_list_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NF = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_queue_linked_list_fifo_if #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(NF)) if_a ();
    multi_queue_linked_list_fifo_if #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(NF)) if_b ();

    multi_queue_linked_list_fifo #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(NF), .MAX_PER_FIFO(4))
        u_a (.clk(clk), .rst(rst), .bus(if_a));
    multi_queue_linked_list_fifo #(.WIDTH(W), .DEPTH(D), .NUM_FIFOS(NF), .MAX_PER_FIFO(2))
        u_b (.clk(clk), .rst(rst), .bus(if_b));

    typedef struct {
        int              d;
        logic [NF-1:0]   empty;
        logic [NF-1:0]   full;
        logic [NF*CW-1:0] count;
        logic [CW-1:0]   free;
        logic            perr;
        logic            oerr;
        logic            dchk;
        logic [W-1:0]    dout;
    } exp_t;

    exp_t       exp_q [$];
    logic [W-1:0] mq [2][NF][$];
    logic       perr_m [2];
    logic       oerr_m [2];
    int         checks   = 0;
    int         failures = 0;

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Expected outputs for the current cycle, then the model advances by the spec rules.
    task automatic model_step(int d, logic pu, logic ps, logic [W-1:0] din, logic po, logic os);
        exp_t e;
        int   tot, cap;
        logic pacc, oacc;
        tot = mq[d][0].size() + mq[d][1].size();
        cap = (d == 0) ? 4 : 2;
        e.d = d;
        e.count = '0;
        for (int q = 0; q < NF; q++) begin
            e.empty[q] = (mq[d][q].size() == 0);
            e.full[q]  = (mq[d][q].size() == cap) || (tot == D);
            e.count[q*CW +: CW] = CW'(mq[d][q].size());
        end
        e.free = CW'(D - tot);
        e.perr = perr_m[d];
        e.oerr = oerr_m[d];
        e.dchk = (mq[d][os].size() != 0);
        e.dout = e.dchk ? mq[d][os][0] : '0;
        exp_q.push_back(e);
        pacc = pu && !e.full[ps];
        oacc = po && !e.empty[os];
        if (oacc) void'(mq[d][os].pop_front());
        if (pacc) mq[d][ps].push_back(din);
        perr_m[d] = pu && !pacc;
        oerr_m[d] = po && !oacc;
    endtask

    task automatic step(int d, logic pu, logic ps, logic [W-1:0] din, logic po, logic os);
        if_a.push = (d == 0) && pu;  if_a.push_sel = (d == 0) ? ps : 1'b0;
        if_a.data_in = din;          if_a.pop = (d == 0) && po;
        if_a.pop_sel = (d == 0) ? os : 1'b0;
        if_b.push = (d == 1) && pu;  if_b.push_sel = (d == 1) ? ps : 1'b0;
        if_b.data_in = din;          if_b.pop = (d == 1) && po;
        if_b.pop_sel = (d == 1) ? os : 1'b0;
        model_step(0, if_a.push, if_a.push_sel, din, if_a.pop, if_a.pop_sel);
        model_step(1, if_b.push, if_b.push_sel, din, if_b.pop, if_b.pop_sel);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int d, logic os);
        step(d, 1'b0, 1'b0, '0, 1'b0, os);
    endtask

    // Requests are driven during reset to show they are ignored.
    task automatic do_reset();
        rst = 1'b1;
        if_a.push = 1'b1; if_a.push_sel = 1'b0; if_a.data_in = 8'hEE; if_a.pop = 1'b1; if_a.pop_sel = 1'b0;
        if_b.push = 1'b1; if_b.push_sel = 1'b1; if_b.data_in = 8'hDD; if_b.pop = 1'b1; if_b.pop_sel = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int q = 0; q < NF; q++) mq[d][q].delete();
            perr_m[d] = 1'b0;
            oerr_m[d] = 1'b0;
        end
    endtask

    exp_t              m_e;
    logic [NF-1:0]     a_empty, a_full;
    logic [NF*CW-1:0]  a_count;
    logic [CW-1:0]     a_free;
    logic              a_perr, a_oerr;
    logic [W-1:0]      a_dout;
    int                a_sum;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            if (m_e.d == 0) begin
                a_empty = if_a.empty; a_full = if_a.full; a_count = if_a.count;
                a_free = if_a.free_count; a_perr = if_a.push_err; a_oerr = if_a.pop_err;
                a_dout = if_a.data_out;
            end else begin
                a_empty = if_b.empty; a_full = if_b.full; a_count = if_b.count;
                a_free = if_b.free_count; a_perr = if_b.push_err; a_oerr = if_b.pop_err;
                a_dout = if_b.data_out;
            end
            check("empty", m_e.d, 32'(a_empty), 32'(m_e.empty));
            check("full", m_e.d, 32'(a_full), 32'(m_e.full));
            check("count", m_e.d, 32'(a_count), 32'(m_e.count));
            check("free_count", m_e.d, 32'(a_free), 32'(m_e.free));
            check("push_err", m_e.d, 32'(a_perr), 32'(m_e.perr));
            check("pop_err", m_e.d, 32'(a_oerr), 32'(m_e.oerr));
            if (m_e.dchk)
                check("data_out", m_e.d, 32'(a_dout), 32'(m_e.dout));
            a_sum = int'(a_free);
            for (int q = 0; q < NF; q++) a_sum += int'(a_count[q*CW +: CW]);
            check("conservation", m_e.d, 32'(a_sum), 32'(D));
        end
    end

    initial begin
        if_a.push = 1'b0; if_a.push_sel = 1'b0; if_a.data_in = '0; if_a.pop = 1'b0; if_a.pop_sel = 1'b0;
        if_b.push = 1'b0; if_b.push_sel = 1'b0; if_b.data_in = '0; if_b.pop = 1'b0; if_b.pop_sel = 1'b0;
        do_reset();

        // basic push/pop ordering across two queues
        step(0, 1, 0, 8'h11, 0, 0);
        step(0, 1, 0, 8'h22, 0, 0);
        step(0, 1, 1, 8'h33, 0, 0);
        idle(0, 0);
        step(0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 1, 1);
        idle(0, 0);

        // fill the shared pool from q0, then a rejected push to q1
        for (int i = 0; i < 4; i++) step(0, 1, 0, W'(8'hA0 + i), 0, 0);
        step(0, 1, 1, 8'hBB, 0, 1);
        idle(0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, 0);

        // pop on empty, and push+pop to the same empty queue
        step(0, 0, 0, '0, 1, 0);
        step(0, 1, 1, 8'h5A, 1, 1);
        idle(0, 1);
        step(0, 0, 0, '0, 1, 1);

        // concurrent push and pop on a non-empty queue
        step(0, 1, 0, 8'h01, 0, 0);
        step(0, 1, 0, 8'h02, 0, 0);
        step(0, 1, 0, 8'h03, 1, 0);
        step(0, 0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 1, 0);
        idle(0, 0);

        // per-queue cap of 2 on the second instance
        for (int i = 0; i < 3; i++) step(1, 1, 0, W'(8'hC0 + i), 0, 0);
        step(1, 1, 1, 8'hD0, 0, 1);
        step(1, 1, 1, 8'hD1, 0, 1);
        idle(1, 1);
        for (int i = 0; i < 2; i++) step(1, 0, 0, '0, 1, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0, '0, 1, 1);
        idle(1, 0);

        // random traffic with a reset in the middle
        for (int c = 0; c < 1000; c++) begin
            if (c == 500) do_reset();
            step(int'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), W'($urandom),
                 $urandom_range(0, 9) < 5, 1'($urandom_range(0, 1)));
        end
        idle(0, 0);

        check("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
